// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller.
// Captures one frame of K soft symbols (parity, systematic, a-priori extrinsic),
// runs half-iterations on an external SISO engine over a start/done handshake,
// keeps the returned extrinsics, and forms hard decisions after each full
// iteration. It stops on convergence (optional) or after MAX_ITER iterations,
// then presents the decoded bits on a valid/ready output.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a frame; capture on in_valid_i
// S_START  | one-cycle siso_start_o pulse for the current half-iteration
// S_WAIT   | SISO busy; its inputs are held until siso_done_i
// S_UPDATE | advance half/iteration, evaluate the stop conditions
// S_OUT    | decoded frame on the output, held until out_ready_i

module turbo_iter_ctrl #(
    parameter int K          = 8,
    parameter int LLR_W      = 9,
    parameter int MAX_ITER   = 16,
    parameter int EARLY_STOP = 1
) (
    input  logic                          clk_p_i,
    input  logic                          reset_n_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [3*K*LLR_W-1:0]          data_i,
    output logic                          siso_start_o,
    output logic                          siso_half_o,
    output logic [K*LLR_W-1:0]            siso_llr_o,
    output logic [K*LLR_W-1:0]            siso_par_o,
    input  logic                          siso_done_i,
    input  logic [K*LLR_W-1:0]            siso_ext_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [K-1:0]                  data_o,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_o,
    output logic                          early_o
);

    localparam int FW     = K * LLR_W;
    localparam int ITER_W = $clog2(MAX_ITER + 1);

    // Last iteration index before the increment that reaches MAX_ITER.
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

    // Symmetric clamp limits at LLR_W+1 bits: +(2^(LLR_W-1)-1) and its negation.
    // The most negative LLR_W code is never produced, keeping the range symmetric.
    localparam logic signed [LLR_W:0] SAT_POS = {2'b00, {(LLR_W-1){1'b1}}};
    localparam logic signed [LLR_W:0] SAT_NEG = {2'b11, {(LLR_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_OUT
    } state_t;

    state_t            state_q;
    logic [FW-1:0]     enc_q;
    logic [FW-1:0]     sys_q;
    logic [FW-1:0]     ext_q;
    logic [K-1:0]      prev_hard_q;
    logic [K-1:0]      data_q;
    logic [ITER_W-1:0] iter_q;
    logic              half_q;
    logic              early_q;
    logic              start_q;

    logic [FW-1:0]     llr_c;
    logic [K-1:0]      hard_c;
    logic [K-1:0]      in_hard_c;

    function automatic logic [LLR_W-1:0] sat_add(input logic [LLR_W-1:0] a,
                                                 input logic [LLR_W-1:0] b);
        logic signed [LLR_W:0] sum;
        sum = $signed({a[LLR_W-1], a}) + $signed({b[LLR_W-1], b});
        if (sum > SAT_POS)
            sat_add = SAT_POS[LLR_W-1:0];
        else if (sum < SAT_NEG)
            sat_add = SAT_NEG[LLR_W-1:0];
        else
            sat_add = sum[LLR_W-1:0];
    endfunction

    // A-priori LLRs and hard decisions from the held sys and ext fields.
    always_comb begin
        llr_c  = '0;
        hard_c = '0;
        for (int k = 0; k < K; k++) begin
            llr_c[k*LLR_W +: LLR_W] = sat_add(sys_q[k*LLR_W +: LLR_W], ext_q[k*LLR_W +: LLR_W]);
            hard_c[k]               = llr_c[k*LLR_W + LLR_W - 1];
        end
    end

    // Hard decisions of the incoming frame, seeding the convergence reference.
    always_comb begin
        in_hard_c = '0;
        for (int k = 0; k < K; k++) begin
            logic [LLR_W-1:0] s;
            s            = sat_add(data_i[FW + k*LLR_W +: LLR_W], data_i[k*LLR_W +: LLR_W]);
            in_hard_c[k] = s[LLR_W-1];
        end
    end

    // Iteration sequencer: capture, half-iteration handshakes, stop decision, output hold.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            enc_q       <= '0;
            sys_q       <= '0;
            ext_q       <= '0;
            prev_hard_q <= '0;
            data_q      <= '0;
            iter_q      <= '0;
            half_q      <= 1'b0;
            early_q     <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        enc_q       <= data_i[2*FW +: FW];
                        sys_q       <= data_i[FW +: FW];
                        ext_q       <= data_i[0 +: FW];
                        prev_hard_q <= in_hard_c;
                        iter_q      <= '0;
                        half_q      <= 1'b0;
                        early_q     <= 1'b0;
                        start_q     <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (siso_done_i) begin
                        ext_q   <= siso_ext_i;
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!half_q) begin
                        half_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end else begin
                        iter_q <= iter_q + 1'b1;
                        // Convergence wins when both stop conditions coincide.
                        if ((EARLY_STOP != 0) && (hard_c == prev_hard_q)) begin
                            early_q <= 1'b1;
                            data_q  <= hard_c;
                            state_q <= S_OUT;
                        end else if (iter_q == LAST_ITER) begin
                            data_q  <= hard_c;
                            state_q <= S_OUT;
                        end else begin
                            prev_hard_q <= hard_c;
                            half_q      <= 1'b0;
                            start_q     <= 1'b1;
                            state_q     <= S_START;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready_i)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = (state_q == S_IDLE);
    assign out_valid_o  = (state_q == S_OUT);
    assign siso_start_o = start_q;
    assign siso_half_o  = half_q;
    assign siso_llr_o   = llr_c;
    assign siso_par_o   = enc_q;
    assign data_o       = data_q;
    assign iter_o       = iter_q;
    assign early_o      = early_q;

endmodule

// File: doc/turbo_iter_ctrl.md
Name: turbo_iter_ctrl

Overview:
- Parametrised iteration controller for the turbo decoder.
- Accepts one frame of K soft symbols as parity (enc), systematic (sys) and a-priori extrinsic (ext) LLR fields, then sequences half-iterations on an external SISO engine through a start/done handshake.
- Holds the returned extrinsic values, forms hard decisions after every full iteration, stops early on convergence or at MAX_ITER, and presents the decoded bits on a valid/ready output.

Parameters:
K, 8, symbols per frame (width of data_o)
LLR_W, 9, two's-complement LLR width per symbol
MAX_ITER, 16, maximum full iterations (two half-iterations each), >=1
EARLY_STOP, 1, 1 = terminate when the hard decision is unchanged across one full iteration

Ports:
clk_p_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  frame valid
in_ready_o  out  1  controller can accept a frame
data_i  in  3*K*LLR_W  {enc, sys, ext}; enc in the top third, ext in the bottom third; symbol k at field bits [k*LLR_W +: LLR_W]
siso_start_o  out  1  one-cycle pulse that starts a half-iteration
siso_half_o  out  1  0 = decoder 1 (natural order), 1 = decoder 2 (interleaved)
siso_llr_o  out  K*LLR_W  a-priori LLR per symbol: sat(sys+ext)
siso_par_o  out  K*LLR_W  registered enc field
siso_done_i  in  1  SISO finished; siso_ext_i valid in the same cycle
siso_ext_i  in  K*LLR_W  new extrinsic LLRs
out_valid_o  out  1  decoded frame valid
out_ready_i  in  1  downstream accepts
data_o  out  K  hard decisions; bit k = 1 when sat(sys[k]+ext[k]) < 0
iter_o  out  $clog2(MAX_ITER+1)  full iterations performed
early_o  out  1  1 = stopped by convergence

Behaviour:
- Reset (async, any state): state = IDLE; all registers and outputs 0, except in_ready_o = 1, which is decoded from IDLE. A half-iteration in flight is abandoned. The SISO engine must be reset by the same signal.
- Saturation: sum is computed at LLR_W+1 bits and clamped to the symmetric range ±(2^(LLR_W-1)-1), i.e. ±255 for LLR_W = 9. The code -2^(LLR_W-1) never appears on siso_llr_o.
- IDLE: in_ready_o = 1. When in_valid_i=1:
  - register enc, sys and ext;
  - set prev_hard = hard(sys+ext), iter = 0, half = 0, early = 0;
  - go to START.
- START: siso_start_o = 1 for exactly one cycle, then go to WAIT. The first start comes 1 cycle after input capture.
- WAIT: hold siso_half_o, siso_llr_o and siso_par_o stable. When siso_done_i=1, set ext <= siso_ext_i and go to UPDATE. siso_done_i in any other state is ignored.
- UPDATE (1 cycle):
  - If half = 0: set half = 1 and go to START.
  - If half = 1: set iter = iter+1 and cur = hard(sys+ext).
    - If EARLY_STOP and cur == prev_hard: set early = 1 and go to OUT.
    - Else if iter+1 == MAX_ITER: go to OUT.
    - Else: set prev_hard = cur, half = 0, go to START.
  - When both stop conditions hold, early = 1.
- OUT:
  - out_valid_o = 1; data_o, iter_o and early_o are registered and held stable.
  - On out_ready_i=1, go to IDLE.
  - in_ready_o = 0 in every state except IDLE, so the next frame is accepted no earlier than the cycle after the output handshake.
- Frame length: a frame costs 2*iter SISO starts. Maximum is 2*MAX_ITER.
- in_valid_i while busy: the frame is not captured. The source holds it (valid/ready rule).

Test Plan:
- Early stop: all sys = +10, ext = 0; SISO model returns ext = +5 on every half -> data_o = 0x00, iter_o = 1, early_o = 1, exactly 2 siso_start_o pulses with siso_half_o = 0 then 1.
- Max iterations: all sys = 0, ext = 0; model returns ext = -1 in half 1 of odd iterations and +1 in half 1 of even iterations -> no convergence, iter_o = 16, early_o = 0, 32 start pulses, data_o = 0x00.
- Saturation:
  - sys[0] = +255, returned ext[0] = +255 -> siso_llr_o field 0 = 0x0FF after the update, data_o[0] = 0;
  - sys[1] = -255, ext[1] = -255 -> field 1 = 0x101, data_o[1] = 1.
- Backpressure: hold out_ready_i = 0 for 5 cycles in OUT -> data_o, iter_o and early_o stay stable, in_ready_o = 0, and a waiting second frame is captured only in IDLE after the handshake.
- Reset mid-WAIT: assert reset_n_i = 0 while the SISO is busy -> outputs clear immediately, in_ready_o = 1; a siso_done_i pulse after release is ignored and the state stays IDLE.
- EARLY_STOP = 0 with the early-stop stimulus -> iter_o = 16, early_o = 0.
